// File: rtl/pipe_pkg.sv
// Shared types for the ID-stage hazard controller.
// Holds the hazard FSM state encoding and register-file constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_STALL   = 2'd1,
    FLUSH_WAIT = 2'd2
  } hz_state_t;

  localparam int REG_AW_DEF = 5;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hit detection for the instruction in IF/ID.
// Register 0 never creates a dependency; Rt only counts when read.
module hazard_cmp
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_idex_rt,
  input  logic              i_idex_rd,
  input  logic [REG_AW-1:0] i_ifid_rs,
  input  logic [REG_AW-1:0] i_ifid_rt,
  input  logic              i_uses_rt,
  output logic              o_hit
);

  logic w_nz;
  logic w_rs_eq;
  logic w_rt_eq;

  assign w_nz    = (i_idex_rt != REG_AW'(REG_ZERO));
  assign w_rs_eq = (i_idex_rt == i_ifid_rs);
  assign w_rt_eq = (i_idex_rt == i_ifid_rt);

  assign o_hit = i_idex_rd && w_nz &&
                 (w_rs_eq || (i_uses_rt && w_rt_eq));

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: multi-cycle load-use stall, freeze, flush.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IDEX__Rt,
  input  logic              IDEX__mem__read,
  input  logic [REG_AW-1:0] IFID__Rs,
  input  logic [REG_AW-1:0] IFID__Rt,
  input  logic              IFID__uses__Rt,
  input  logic              EX__br__taken,
  input  logic              mem__busy,
  output logic              pc__load,
  output logic              IFID__Ld,
  output logic              IFID__flush,
  output logic              IDEX__bubble,
  output logic              pipe__freeze,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf__stall,
  output logic [31:0]       perf__flush,
`endif
  output logic              stall__active
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  hz_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sa;

  hz_state_t        w_nst;
  logic [CNT_W-1:0] w_ncnt;
  logic             w_hit;
  logic             w_frz_c;
  logic             w_fl_c;
  logic             w_st_c;
  logic             w_pc;
  logic             w_ld;
  logic             w_fl;
  logic             w_bub;
  logic             w_frz;
  logic             w_stall;

  hazard_cmp #(
    .REG_AW (REG_AW)
  ) u_cmp (
    .i_idex_rt (IDEX__Rt),
    .i_idex_rd (IDEX__mem__read),
    .i_ifid_rs (IFID__Rs),
    .i_ifid_rt (IFID__Rt),
    .i_uses_rt (IFID__uses__Rt),
    .o_hit     (w_hit)
  );

  // a pending flush fires only once the memory stops holding the pipe
  assign w_frz_c = mem__busy;
  assign w_fl_c  = !mem__busy &&
                   (EX__br__taken || r_state == FLUSH_WAIT);
  assign w_st_c  = !mem__busy && !w_fl_c &&
                   (r_state == LU_STALL ||
                    (r_state == RUN && w_hit));

  // enables and next state, freeze > flush > stall > idle
  always_comb begin
    w_pc    = 1'b1;
    w_ld    = 1'b1;
    w_fl    = 1'b0;
    w_bub   = 1'b0;
    w_frz   = 1'b0;
    w_stall = 1'b0;
    w_nst   = r_state;
    w_ncnt  = r_cnt;
    unique case (1'b1)
      w_frz_c: begin
        w_pc  = 1'b0;
        w_ld  = 1'b0;
        w_frz = 1'b1;
        if (EX__br__taken)
          w_nst = FLUSH_WAIT;
      end
      w_fl_c: begin
        w_fl   = 1'b1;
        w_bub  = 1'b1;
        w_nst  = RUN;
        w_ncnt = '0;
      end
      w_st_c: begin
        w_pc    = 1'b0;
        w_ld    = 1'b0;
        w_bub   = 1'b1;
        w_stall = 1'b1;
        if (r_state == LU_STALL) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_nst  = RUN;
            w_ncnt = '0;
          end else begin
            w_ncnt = r_cnt - CNT_W'(1);
          end
        end else if (MEM_LAT > 1) begin
          w_nst  = LU_STALL;
          w_ncnt = CNT_W'(MEM_LAT - 1);
        end
      end
      default: begin
        w_pc = 1'b1;
      end
    endcase
  end

  // FSM state, remaining stall count and registered stall flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_sa    <= 1'b0;
    end else begin
      r_state <= w_nst;
      r_cnt   <= w_ncnt;
      r_sa    <= (w_nst == LU_STALL);
    end
  end

  assign pc__load      = w_pc;
  assign IFID__Ld      = w_ld;
  assign IFID__flush   = w_fl;
  assign IDEX__bubble  = w_bub;
  assign pipe__freeze  = w_frz;
  assign stall__active = r_sa;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_pst;
  logic [31:0] r_pfl;

  // saturating counts of stall cycles and flush events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pst <= '0;
      r_pfl <= '0;
    end else begin
      if (w_stall && r_pst != '1)
        r_pst <= r_pst + 32'd1;
      if (w_fl && r_pfl != '1)
        r_pfl <= r_pfl + 32'd1;
    end
  end

  assign perf__stall = r_pst;
  assign perf__flush = r_pfl;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl at MEM_LAT=1 and MEM_LAT=3.
// Expected output vectors are queued as stimulus is applied.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] idrt;
    logic       rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       br;
    logic       busy;
  } stim_t;

  // output vector order: pc, ifid_ld, flush, bubble, freeze, stall_active
  localparam logic [5:0] IDL = 6'b110000;
  localparam logic [5:0] ST0 = 6'b000100;
  localparam logic [5:0] ST1 = 6'b000101;
  localparam logic [5:0] FZ1 = 6'b000011;
  localparam logic [5:0] FZ0 = 6'b000010;
  localparam logic [5:0] FL0 = 6'b111100;
  localparam logic [5:0] FL1 = 6'b111101;

  localparam stim_t NP    = '0;
  localparam stim_t LD    = {5'd5, 1'b1, 5'd5, 5'd0, 3'b000};
  localparam stim_t LDBR  = {5'd5, 1'b1, 5'd5, 5'd0, 3'b010};
  localparam stim_t LDBSY = {5'd5, 1'b1, 5'd5, 5'd0, 3'b001};
  localparam stim_t BSY   = {5'd0, 1'b0, 5'd0, 5'd0, 3'b001};
  localparam stim_t BB    = {5'd0, 1'b0, 5'd0, 5'd0, 3'b011};
  localparam stim_t Z0    = {5'd0, 1'b1, 5'd0, 5'd0, 3'b100};
  localparam stim_t NRD   = {5'd5, 1'b0, 5'd5, 5'd5, 3'b100};
  localparam stim_t RTN   = {5'd7, 1'b1, 5'd3, 5'd7, 3'b000};
  localparam stim_t RTU   = {5'd7, 1'b1, 5'd3, 5'd7, 3'b100};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] idex_rt = '0;
  logic       idex_rd = 1'b0;
  logic [4:0] ifid_rs = '0;
  logic [4:0] ifid_rt = '0;
  logic       uses_rt = 1'b0;
  logic       br = 1'b0;
  logic       busy = 1'b0;

  logic pc1, ld1, fl1, bub1, frz1, sa1;
  logic pc3, ld3, fl3, bub3, frz3, sa3;
`ifdef HAZARD_PERF_EN
  logic [31:0] ps1, pf1, ps3, pf3;
`endif

  logic [5:0] sb[$];
  int n_pass = 0;
  int n_total = 0;

  wire [5:0] o1 = {pc1, ld1, fl1, bub1, frz1, sa1};
  wire [5:0] o3 = {pc3, ld3, fl3, bub3, frz3, sa3};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .MEM_LAT(1)) dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .IDEX__Rt        (idex_rt),
    .IDEX__mem__read (idex_rd),
    .IFID__Rs        (ifid_rs),
    .IFID__Rt        (ifid_rt),
    .IFID__uses__Rt  (uses_rt),
    .EX__br__taken   (br),
    .mem__busy       (busy),
    .pc__load        (pc1),
    .IFID__Ld        (ld1),
    .IFID__flush     (fl1),
    .IDEX__bubble    (bub1),
    .pipe__freeze    (frz1),
`ifdef HAZARD_PERF_EN
    .perf__stall     (ps1),
    .perf__flush     (pf1),
`endif
    .stall__active   (sa1)
  );

  hazard_ctrl #(.REG_AW(5), .MEM_LAT(3)) dut3 (
    .clk             (clk),
    .rst_n           (rst_n),
    .IDEX__Rt        (idex_rt),
    .IDEX__mem__read (idex_rd),
    .IFID__Rs        (ifid_rs),
    .IFID__Rt        (ifid_rt),
    .IFID__uses__Rt  (uses_rt),
    .EX__br__taken   (br),
    .mem__busy       (busy),
    .pc__load        (pc3),
    .IFID__Ld        (ld3),
    .IFID__flush     (fl3),
    .IDEX__bubble    (bub3),
    .pipe__freeze    (frz3),
`ifdef HAZARD_PERF_EN
    .perf__stall     (ps3),
    .perf__flush     (pf3),
`endif
    .stall__active   (sa3)
  );

  task automatic apply(input stim_t s, input logic [5:0] e);
    idex_rt = s.idrt;
    idex_rd = s.rd;
    ifid_rs = s.rs;
    ifid_rt = s.rt;
    uses_rt = s.uses;
    br      = s.br;
    busy    = s.busy;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    apply(NP, IDL);
    void'(sb.pop_back());
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    rst_n = 1'b0;
    apply(NP, IDL);
    apply(NP, IDL);
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (o3 !== e) $display("FAIL reset3 got %b exp %b", o3, e);
    else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (o1 !== e) $display("FAIL reset1 got %b exp %b", o1, e);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lat1();
    stim_t st[6];
    logic [5:0] ex[6];
    logic [5:0] e;
    st = '{LD, NP, LD, LD, NP, NP};
    ex = '{ST0, IDL, ST0, ST0, IDL, IDL};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      if (o1 !== e) $display("FAIL lat1 cyc%0d got %b exp %b", i, o1, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lat3();
    stim_t st[8];
    logic [5:0] ex[8];
    logic [5:0] e;
    st = '{LD, LD, NP, LD, NP, NP, NP, NP};
    ex = '{ST0, ST1, ST1, ST0, ST1, ST1, IDL, IDL};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      if (o3 !== e) $display("FAIL lat3 cyc%0d got %b exp %b", i, o3, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_zero_reg();
    stim_t st[7];
    logic [5:0] ex[7];
    logic [5:0] e;
    st = '{NRD, Z0, RTN, RTU, NP, NP, NP};
    ex = '{IDL, IDL, IDL, ST0, ST1, ST1, IDL};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      if (o3 !== e) $display("FAIL zero cyc%0d got %b exp %b", i, o3, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    stim_t st[6];
    logic [5:0] ex[6];
    logic [5:0] e;
    st = '{LD, LDBR, NP, LDBR, NP, NP};
    ex = '{ST0, FL1, IDL, FL0, IDL, IDL};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      if (o3 !== e) $display("FAIL branch cyc%0d got %b exp %b", i, o3, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_busy();
    stim_t st[16];
    logic [5:0] ex[16];
    logic [5:0] e;
    st = '{LD, BSY, BSY, NP, NP, NP,
           LD, BB, BSY, NP, NP,
           LDBSY, LD, NP, NP, NP};
    ex = '{ST0, FZ1, FZ1, ST1, ST1, IDL,
           ST0, FZ1, FZ0, FL0, IDL,
           FZ0, ST0, ST1, ST1, IDL};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      if (o3 !== e) $display("FAIL busy cyc%0d got %b exp %b", i, o3, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    do_reset();
    apply(LD, ST0);
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (o3 !== e) $display("FAIL rstmid_a got %b exp %b", o3, e);
    else n_pass++;
    @(posedge clk);
    #1;
    apply(NP, ST1);
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (o3 !== e) $display("FAIL rstmid_b got %b exp %b", o3, e);
    else n_pass++;
    rst_n = 1'b0;
    apply(NP, IDL);
    #1;
    e = sb.pop_front();
    n_total++;
    if (o3 !== e) $display("FAIL rstmid_c got %b exp %b", o3, e);
    else n_pass++;
`ifdef HAZARD_PERF_EN
    n_total++;
    if (ps3 !== 32'd0 || pf3 !== 32'd0)
      $display("FAIL rstmid_perf got %0d/%0d exp 0/0", ps3, pf3);
    else n_pass++;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(NP, IDL);
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (o3 !== e) $display("FAIL rstmid_d got %b exp %b", o3, e);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    test_reset();
    test_lat1();
    test_lat3();
    test_zero_reg();
    test_branch();
    test_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
